// File: rtl/accelbrot_com_abs.sv
// accelbrot_com_abs: converts a word-serial two's-complement number (LSW first)
// into an unsigned magnitude stream plus one sign bit per number.
// The sign is only known at the last word, so each number is buffered in one
// of two ping-pong banks and then replayed, negated serially when negative.
// Optional feature macro: ACCELBROT_COM_ABS_ZERO_FLAG_EN adds out_zero, which
// flags numbers whose words were all zero.
module accelbrot_com_abs #(
  parameter int WWIDTH = 34,
  parameter int NWORDS = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WWIDTH-1:0] in,
  input  logic              in_start,
  input  logic              in_valid,
  output logic [WWIDTH-1:0] out,
  output logic              out_sign,
  output logic              out_start,
  output logic              out_valid
`ifdef ACCELBROT_COM_ABS_ZERO_FLAG_EN
  , output logic            out_zero
`endif
);

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  // Two banks of NWORDS words each
  logic [WWIDTH-1:0] mem_reg [2][NWORDS];

  // Write side: wr_cnt_reg is the next position to fill; 0 means no frame open
  logic          wr_bank_reg;
  logic [IW-1:0] wr_cnt_reg;
  logic [1:0]    full_reg;
  logic [1:0]    sign_reg;

  // Read side: rd_idx_reg is the index of the word currently on out
  logic          busy_reg;
  logic          rd_bank_reg;
  logic [IW-1:0] rd_idx_reg;
  logic          carry_reg;

  logic          wr_first, wr_more, wr_en, complete;
  logic [IW-1:0] wr_idx;
  logic          rd_last, can_start, next_bank, start, start_sign, cont;
  logic          sel_bank, sel_carry, sel_sign;
  logic [IW-1:0] sel_idx;
  logic [WWIDTH-1:0] rd_word, neg_word, conv_word;
  logic          neg_carry;

  assign wr_first = in_valid && in_start;
  assign wr_more  = in_valid && !in_start && (wr_cnt_reg != '0);
  assign wr_en    = wr_first || wr_more;
  assign wr_idx   = wr_first ? '0 : wr_cnt_reg;
  assign complete = wr_more && (wr_cnt_reg == LAST);

  // A new frame may begin when idle or in the cycle the previous frame emits
  // its last word, so back-to-back numbers stream without gaps. A bank that
  // completes this cycle can start immediately: its word 0 is already stored
  // and its sign is taken straight from the incoming last word.
  assign rd_last    = busy_reg && (rd_idx_reg == LAST);
  assign can_start  = !busy_reg || rd_last;
  assign next_bank  = busy_reg ? ~rd_bank_reg : rd_bank_reg;
  assign start      = can_start && (full_reg[next_bank] || (complete && (wr_bank_reg == next_bank)));
  assign start_sign = full_reg[next_bank] ? sign_reg[next_bank] : in[WWIDTH-1];
  assign cont       = busy_reg && !rd_last;

  // Select which stored word feeds the output register and its carry-in
  always_comb begin
    sel_bank  = rd_bank_reg;
    sel_idx   = rd_idx_reg + IW'(1);
    sel_carry = carry_reg;
    sel_sign  = out_sign;
    if (start) begin
      sel_bank  = next_bank;
      sel_idx   = '0;
      sel_carry = 1'b1;
      sel_sign  = start_sign;
    end
  end

  assign rd_word = mem_reg[sel_bank][sel_idx];
  // Serial negation: ~word + carry, carry-out chains into the next word
  assign {neg_carry, neg_word} = {1'b0, ~rd_word} + {{WWIDTH{1'b0}}, sel_carry};
  assign conv_word = sel_sign ? neg_word : rd_word;

`ifdef ACCELBROT_COM_ABS_ZERO_FLAG_EN
  logic       in_zero;
  logic       zacc_reg;
  logic [1:0] zero_reg;
  logic       start_zero;

  assign in_zero    = (in == '0);
  assign start_zero = full_reg[next_bank] ? zero_reg[next_bank] : (zacc_reg && in_zero);

  // Running all-zero flag of the open frame, latched per bank on completion
  always_ff @(posedge clk) begin
    if (!rstn) begin
      zacc_reg <= 1'b0;
      zero_reg <= '0;
    end else begin
      if (wr_first)
        zacc_reg <= in_zero;
      else if (wr_more)
        zacc_reg <= zacc_reg && in_zero;
      if (complete)
        zero_reg[wr_bank_reg] <= zacc_reg && in_zero;
    end
  end
`endif

  // Word storage; no reset needed, the full flags gate all reads
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_reg[wr_bank_reg][wr_idx] <= in;
  end

  // Input framing: open on in_start, restart on a mid-frame in_start, toggle bank on completion
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_bank_reg <= 1'b0;
      wr_cnt_reg  <= '0;
    end else if (wr_first) begin
      wr_cnt_reg <= IW'(1);
    end else if (wr_more) begin
      if (complete) begin
        wr_cnt_reg  <= '0;
        wr_bank_reg <= ~wr_bank_reg;
      end else begin
        wr_cnt_reg <= wr_cnt_reg + IW'(1);
      end
    end
  end

  // Bank status: freed after its last word is emitted, filled on completion
  always_ff @(posedge clk) begin
    if (!rstn) begin
      full_reg <= '0;
      sign_reg <= '0;
    end else begin
      if (rd_last)
        full_reg[rd_bank_reg] <= 1'b0;
      if (complete) begin
        full_reg[wr_bank_reg] <= 1'b1;
        sign_reg[wr_bank_reg] <= in[WWIDTH-1];
      end
    end
  end

  // Read sequencing: word index, current bank and the negation carry
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_reg    <= 1'b0;
      rd_bank_reg <= 1'b0;
      rd_idx_reg  <= '0;
      carry_reg   <= 1'b1;
    end else if (start) begin
      busy_reg    <= 1'b1;
      rd_bank_reg <= next_bank;
      rd_idx_reg  <= '0;
      carry_reg   <= neg_carry;
    end else if (cont) begin
      rd_idx_reg <= rd_idx_reg + IW'(1);
      carry_reg  <= neg_carry;
    end else if (rd_last) begin
      busy_reg    <= 1'b0;
      rd_bank_reg <= ~rd_bank_reg;
      carry_reg   <= 1'b1;
    end
  end

  // Registered outputs; cleared between frames
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out       <= '0;
      out_sign  <= 1'b0;
      out_start <= 1'b0;
      out_valid <= 1'b0;
`ifdef ACCELBROT_COM_ABS_ZERO_FLAG_EN
      out_zero  <= 1'b0;
`endif
    end else if (start || cont) begin
      out       <= conv_word;
      out_sign  <= sel_sign;
      out_start <= start;
      out_valid <= 1'b1;
`ifdef ACCELBROT_COM_ABS_ZERO_FLAG_EN
      out_zero  <= start ? start_zero : out_zero;
`endif
    end else begin
      out       <= '0;
      out_sign  <= 1'b0;
      out_start <= 1'b0;
      out_valid <= 1'b0;
`ifdef ACCELBROT_COM_ABS_ZERO_FLAG_EN
      out_zero  <= 1'b0;
`endif
    end
  end

endmodule
